// File: rtl/main_control_fsm.sv
// Multi-cycle main control FSM for the 32-bit RISC core: sequences fetch/decode/execute/
// memory/write-back and drives the datapath strobes; branches resolve from ALU zero/neg.
module main_control_fsm #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         OpCode,
  input  logic               zero,
  input  logic               neg,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               ir_write,
  output logic               mem_read,
  output logic               mem_write,
  output logic               reg_write,
  output logic               wb_sel,
  output logic               alu_src_b,
  output logic [1:0]         pc_src,
  output logic               sp_inc,
  output logic               sp_dec,
  output logic               base_inc,
  output logic               illegal,
  output logic [STATE_W-1:0] state
);

  typedef enum logic [3:0] {
    FETCH, DECODE, EXEC_R, EXEC_I, WB_ALU, ADDR, MEM_RD, MEM_WR,
    WB_MEM, POI_INC, BRANCH, JUMP, CALL, RET, PUSH, POP
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       wb_sel;
    logic       alu_src_b;
    logic [1:0] pc_src;
    logic       sp_inc;
    logic       sp_dec;
    logic       base_inc;
    logic       illegal;
  } ctl_t;

  state_t cur, nxt;
  ctl_t   ctl, ctl_o;
  logic   taken;

  always_ff @(posedge clk) begin
    if (!rst_n) cur <= FETCH;
    else        cur <= nxt;
  end

  always_comb begin
    case (OpCode)
      6'd8:    taken = !zero && !neg;
      6'd9:    taken = neg;
      6'd10:   taken = zero;
      6'd11:   taken = !zero;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    nxt = cur;
    case (cur)
      FETCH:   if (mem_ready) nxt = DECODE;
      DECODE: begin
        if      (OpCode <= 6'd2)  nxt = EXEC_R;
        else if (OpCode <= 6'd4)  nxt = EXEC_I;
        else if (OpCode <= 6'd7)  nxt = ADDR;
        else if (OpCode <= 6'd11) nxt = BRANCH;
        else if (OpCode == 6'd12) nxt = JUMP;
        else if (OpCode == 6'd13) nxt = CALL;
        else if (OpCode == 6'd14) nxt = RET;
        else if (OpCode == 6'd15) nxt = PUSH;
        else if (OpCode == 6'd16) nxt = POP;
        else                      nxt = FETCH;
      end
      EXEC_R, EXEC_I: nxt = WB_ALU;
      ADDR:    nxt = (OpCode == 6'd7) ? MEM_WR : MEM_RD;
      MEM_RD:  if (mem_ready) nxt = WB_MEM;
      POP:     if (mem_ready) nxt = WB_MEM;
      MEM_WR, CALL, RET, PUSH: if (mem_ready) nxt = FETCH;
      WB_MEM:  nxt = (OpCode == 6'd6) ? POI_INC : FETCH;
      default: nxt = FETCH;
    endcase
  end

  // Architectural updates in wait states fire only on the completing cycle.
  always_comb begin
    ctl = '0;
    case (cur)
      FETCH: begin
        ctl.mem_read = 1'b1;
        ctl.ir_write = mem_ready;
        ctl.pc_write = mem_ready;
      end
      DECODE:  ctl.illegal   = (OpCode > 6'd16);
      EXEC_I:  ctl.alu_src_b = 1'b1;
      ADDR:    ctl.alu_src_b = 1'b1;
      WB_ALU:  ctl.reg_write = 1'b1;
      MEM_RD:  ctl.mem_read  = 1'b1;
      MEM_WR:  ctl.mem_write = 1'b1;
      WB_MEM: begin
        ctl.reg_write = 1'b1;
        ctl.wb_sel    = 1'b1;
      end
      POI_INC: ctl.base_inc = 1'b1;
      BRANCH: begin
        ctl.pc_src   = 2'b01;
        ctl.pc_write = taken;
      end
      JUMP: begin
        ctl.pc_src   = 2'b10;
        ctl.pc_write = 1'b1;
      end
      CALL: begin
        ctl.mem_write = 1'b1;
        ctl.pc_src    = 2'b10;
        ctl.pc_write  = mem_ready;
        ctl.sp_dec    = mem_ready;
      end
      RET: begin
        ctl.mem_read = 1'b1;
        ctl.pc_src   = 2'b11;
        ctl.pc_write = mem_ready;
        ctl.sp_inc   = mem_ready;
      end
      PUSH: begin
        ctl.mem_write = 1'b1;
        ctl.sp_dec    = mem_ready;
      end
      POP: begin
        ctl.mem_read = 1'b1;
        ctl.sp_inc   = mem_ready;
      end
      default: ctl = '0;
    endcase
  end

  // Reset gates every output so a mid-instruction reset leaves no partial write.
  assign ctl_o     = rst_n ? ctl : '0;
  assign pc_write  = ctl_o.pc_write;
  assign ir_write  = ctl_o.ir_write;
  assign mem_read  = ctl_o.mem_read;
  assign mem_write = ctl_o.mem_write;
  assign reg_write = ctl_o.reg_write;
  assign wb_sel    = ctl_o.wb_sel;
  assign alu_src_b = ctl_o.alu_src_b;
  assign pc_src    = ctl_o.pc_src;
  assign sp_inc    = ctl_o.sp_inc;
  assign sp_dec    = ctl_o.sp_dec;
  assign base_inc  = ctl_o.base_inc;
  assign illegal   = ctl_o.illegal;
  assign state     = rst_n ? STATE_W'(cur) : '0;

endmodule

// File: tb/tb_main_control_fsm.sv
// Bench for main_control_fsm: a per-instruction step list built from the instruction
// timing rules is replayed cycle by cycle and compared against the DUT.
module tb_main_control_fsm;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic [5:0] OpCode = '0;
  logic       zero = 1'b0, neg = 1'b0, mem_ready = 1'b0;
  logic       pc_write, ir_write, mem_read, mem_write, reg_write, wb_sel, alu_src_b;
  logic [1:0] pc_src;
  logic       sp_inc, sp_dec, base_inc, illegal;
  logic [3:0] state;
  logic [12:0] act;

  localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_EXEC_R = 4'd2, S_EXEC_I = 4'd3,
    S_WB_ALU = 4'd4, S_ADDR = 4'd5, S_MEM_RD = 4'd6, S_MEM_WR = 4'd7, S_WB_MEM = 4'd8,
    S_POI_INC = 4'd9, S_BRANCH = 4'd10, S_JUMP = 4'd11, S_CALL = 4'd12, S_RET = 4'd13,
    S_PUSH = 4'd14, S_POP = 4'd15;

  localparam logic [12:0] PCW = 13'h1000, IRW = 13'h0800, MR = 13'h0400, MW = 13'h0200,
    RW = 13'h0100, WBS = 13'h0080, ASB = 13'h0040, PS_BR = 13'h0010, PS_J = 13'h0020,
    PS_M = 13'h0030, SPI = 13'h0008, SPD = 13'h0004, BI = 13'h0002, ILL = 13'h0001,
    NONE = 13'h0000;

  typedef struct {
    logic [3:0]  st;
    logic [12:0] o;
    logic [5:0]  op;
    logic        rdy, z, n;
  } step_t;

  step_t      q[$];
  logic [5:0] bop;
  int         n_cmp = 0, n_bad = 0;

  main_control_fsm #(.STATE_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .OpCode(OpCode), .zero(zero), .neg(neg),
    .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .wb_sel(wb_sel), .alu_src_b(alu_src_b), .pc_src(pc_src), .sp_inc(sp_inc),
    .sp_dec(sp_dec), .base_inc(base_inc), .illegal(illegal), .state(state)
  );

  assign act = {pc_write, ir_write, mem_read, mem_write, reg_write, wb_sel, alu_src_b,
                pc_src, sp_inc, sp_dec, base_inc, illegal};

  always #5 clk = ~clk;

  function automatic int pick(input int w);
    return (w < 0) ? int'($urandom_range(0, 2)) : w;
  endfunction

  task automatic add(input logic [3:0] st, input logic [12:0] o, input logic rdy);
    step_t s;
    s.st = st; s.o = o; s.op = bop; s.rdy = rdy;
    s.z = 1'($urandom_range(0, 1)); s.n = 1'($urandom_range(0, 1));
    q.push_back(s);
  endtask

  // Memory step: w stalled cycles, then the completing cycle.
  task automatic mem(input logic [3:0] st, input logic [12:0] ow, input logic [12:0] orr,
                     input int w);
    repeat (w) add(st, ow, 1'b0);
    add(st, orr, 1'b1);
  endtask

  task automatic build(input logic [5:0] op, input int fw, input int mw,
                       input logic z, input logic n);
    logic t;
    bop = op;
    mem(S_FETCH, MR, MR | IRW | PCW, pick(fw));
    if (op > 6'd16) begin
      add(S_DECODE, ILL, 1'($urandom_range(0, 1)));
      return;
    end
    add(S_DECODE, NONE, 1'($urandom_range(0, 1)));
    if (op <= 2) begin
      add(S_EXEC_R, NONE, 1'($urandom_range(0, 1)));
      add(S_WB_ALU, RW, 1'($urandom_range(0, 1)));
    end else if (op <= 4) begin
      add(S_EXEC_I, ASB, 1'($urandom_range(0, 1)));
      add(S_WB_ALU, RW, 1'($urandom_range(0, 1)));
    end else if (op <= 6) begin
      add(S_ADDR, ASB, 1'($urandom_range(0, 1)));
      mem(S_MEM_RD, MR, MR, pick(mw));
      add(S_WB_MEM, RW | WBS, 1'($urandom_range(0, 1)));
      if (op == 6) add(S_POI_INC, BI, 1'($urandom_range(0, 1)));
    end else if (op == 7) begin
      add(S_ADDR, ASB, 1'($urandom_range(0, 1)));
      mem(S_MEM_WR, MW, MW, pick(mw));
    end else if (op <= 11) begin
      case (op)
        6'd8:    t = !z && !n;
        6'd9:    t = n;
        6'd10:   t = z;
        default: t = !z;
      endcase
      add(S_BRANCH, PS_BR | (t ? PCW : NONE), 1'($urandom_range(0, 1)));
      q[q.size()-1].z = z;
      q[q.size()-1].n = n;
    end else if (op == 12) add(S_JUMP, PS_J | PCW, 1'($urandom_range(0, 1)));
    else if (op == 13) mem(S_CALL, MW | PS_J, MW | PS_J | PCW | SPD, pick(mw));
    else if (op == 14) mem(S_RET, MR | PS_M, MR | PS_M | PCW | SPI, pick(mw));
    else if (op == 15) mem(S_PUSH, MW, MW | SPD, pick(mw));
    else begin
      mem(S_POP, MR, MR | SPI, pick(mw));
      add(S_WB_MEM, RW | WBS, 1'($urandom_range(0, 1)));
    end
  endtask

  // Entered #1 after a rising edge; leaves the same way.
  task automatic run(input int n, input string tag);
    step_t s;
    for (int i = 0; i < n && q.size() > 0; i++) begin
      s = q.pop_front();
      OpCode = s.op; mem_ready = s.rdy; zero = s.z; neg = s.n;
      @(negedge clk);
      n_cmp++;
      if (state !== s.st || act !== s.o) begin
        n_bad++;
        $display("FAIL %s step %0d op %0d: got state %0d outs %h, expected state %0d outs %h",
                 tag, i, s.op, state, act, s.st, s.o);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    n_cmp++;
    if (state !== S_FETCH || act !== NONE) begin
      n_bad++;
      $display("FAIL reset: got state %0d outs %h, expected state 0 outs 0000", state, act);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_add;
    build(6'd1, 0, 0, 1'b0, 1'b0);
    run(q.size(), "add");
  endtask

  task automatic test_lwpoi;
    build(6'd6, 0, 2, 1'b0, 1'b0);
    run(q.size(), "lwpoi");
  endtask

  task automatic test_branch;
    build(6'd8, 0, 0, 1'b0, 1'b0); run(q.size(), "bgt_taken");
    build(6'd8, 0, 0, 1'b1, 1'b0); run(q.size(), "bgt_zero");
    build(6'd8, 0, 0, 1'b0, 1'b1); run(q.size(), "bgt_neg");
    build(6'd11, 0, 0, 1'b0, 1'b0); run(q.size(), "bne_taken");
    build(6'd11, 0, 0, 1'b1, 1'b0); run(q.size(), "bne_not");
    build(6'd9, 0, 0, 1'b0, 1'b1); run(q.size(), "blt_taken");
    build(6'd9, 0, 0, 1'b1, 1'b0); run(q.size(), "blt_not");
    build(6'd10, 0, 0, 1'b1, 1'b0); run(q.size(), "beq_taken");
    build(6'd10, 0, 0, 1'b0, 1'b1); run(q.size(), "beq_not");
  endtask

  task automatic test_illegal;
    build(6'd40, 0, 0, 1'b0, 1'b0); run(q.size(), "illegal40");
    build(6'd17, 1, 0, 1'b0, 1'b0); run(q.size(), "illegal17");
    build(6'd63, 0, 0, 1'b0, 1'b0); run(q.size(), "illegal63");
  endtask

  task automatic test_call_ret;
    build(6'd13, 0, 1, 1'b0, 1'b0); run(q.size(), "call");
    build(6'd14, 0, 0, 1'b0, 1'b0); run(q.size(), "ret");
    build(6'd15, 0, 2, 1'b0, 1'b0); run(q.size(), "push");
    build(6'd16, 0, 1, 1'b0, 1'b0); run(q.size(), "pop");
  endtask

  task automatic test_reset_midwait;
    build(6'd7, 0, 3, 1'b0, 1'b0);
    run(4, "sw_pre_reset");
    q.delete();
    rst_n = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (act !== NONE) begin
      n_bad++;
      $display("FAIL reset_midwait_gate: got outs %h, expected 0000", act);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (state !== S_FETCH || act !== MR) begin
      n_bad++;
      $display("FAIL reset_midwait_after: got state %0d outs %h, expected state 0 outs %h",
               state, act, MR);
    end
    @(posedge clk); #1;
    build(6'd4, 0, 0, 1'b0, 1'b0);
    run(q.size(), "resume_addi");
  endtask

  task automatic test_random;
    logic [5:0] op;
    for (int k = 0; k < 300; k++) begin
      op = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(17, 63)) : 6'($urandom_range(0, 16));
      build(op, -1, -1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      run(q.size(), "random");
    end
    @(negedge clk);
    n_cmp++;
    if (state !== S_FETCH) begin
      n_bad++;
      $display("FAIL final_fetch: got state %0d, expected 0", state);
    end
  endtask

  initial begin
    test_reset;
    test_add;
    test_lwpoi;
    test_branch;
    test_illegal;
    test_call_ret;
    test_reset_midwait;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
